// File: rtl/fifo_if.sv
// fifo_if: write/read handshake and status bundle for the flit FIFO.
interface fifo_if #(
    parameter int DATA_WIDTH   = 18,
    parameter int FIFO_SIZE    = 64,
    parameter int ADDRESS_SIZE = 4
);
    logic                               wr_en;
    logic [DATA_WIDTH-1:0]              wr_data;
    logic                               rd_en;
    logic [DATA_WIDTH-1:0]              rd_data;
    logic                               empty;
    logic                               full;
    logic [$clog2(FIFO_SIZE+1)-1:0]     count;
    logic [ADDRESS_SIZE-1:0]            pkt_address;
    modport master (output wr_en, wr_data, rd_en, input rd_data, empty, full, count, pkt_address);
    modport slave  (input wr_en, wr_data, rd_en, output rd_data, empty, full, count, pkt_address);
endinterface

// File: rtl/fifo.sv
// fifo: first-word-fall-through flit store that latches the last header's destination.
module fifo #(
    parameter int DATA_WIDTH   = 18,
    parameter int FIFO_SIZE    = 64,
    parameter int ADDRESS_SIZE = 4
) (
    input logic   clk,
    input logic   rst,
    fifo_if.slave bus
);
    localparam int PW = $clog2(FIFO_SIZE);
    localparam int CW = $clog2(FIFO_SIZE + 1);
    logic [DATA_WIDTH-1:0]   mem [FIFO_SIZE];
    logic [PW-1:0]           wptr, rptr;
    logic [CW-1:0]           cnt;
    logic [ADDRESS_SIZE-1:0] addr;
    logic                    wr_ok, rd_ok, hdr;
    assign bus.empty       = cnt == '0;
    assign bus.full        = cnt == CW'(FIFO_SIZE);
    assign bus.count       = cnt;
    assign bus.pkt_address = addr;
    assign bus.rd_data     = bus.empty ? '0 : mem[rptr];
    assign rd_ok = bus.rd_en && !bus.empty;
    // a read frees a slot in the same edge, so a full FIFO still accepts a paired write
    assign wr_ok = bus.wr_en && (!bus.full || bus.rd_en);
    assign hdr   = bus.wr_data[DATA_WIDTH-1 -: 2] == 2'b01;
    always_ff @(posedge clk)
        if (wr_ok) mem[wptr] <= bus.wr_data;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            addr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr == PW'(FIFO_SIZE - 1) ? '0 : wptr + PW'(1);
            if (rd_ok) rptr <= rptr == PW'(FIFO_SIZE - 1) ? '0 : rptr + PW'(1);
            if (wr_ok && hdr) addr <= bus.wr_data[ADDRESS_SIZE-1:0];
            cnt <= cnt + CW'(wr_ok) - CW'(rd_ok);
        end
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: scoreboard bench for a 64-deep and a 5-deep flit FIFO.
module tb_fifo;
    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int failures = 0;
    logic [17:0] q[$];
    logic [17:0] sq[$];
    logic [3:0] ma = 0;
    fifo_if b ();
    fifo_if #(.FIFO_SIZE(5)) s ();
    fifo u_big (.clk(clk), .rst(rst), .bus(b));
    fifo #(.FIFO_SIZE(5)) u_small (.clk(clk), .rst(rst), .bus(s));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic w, input logic [17:0] d, input logic r);
        logic wok, rok;
        b.wr_en = w; b.wr_data = d; b.rd_en = r;
        rok = r && q.size() > 0;
        wok = w && (q.size() < 64 || r);
        if (rok) check("rd_head", 32'(b.rd_data), 32'(q.pop_front()));
        if (wok) begin
            q.push_back(d);
            if (d[17:16] == 2'b01) ma = d[3:0];
        end
        @(posedge clk); #1;
        b.wr_en = 0; b.rd_en = 0;
        check("count", 32'(b.count), 32'(q.size()));
        check("empty", 32'(b.empty), 32'(q.size() == 0));
        check("full", 32'(b.full), 32'(q.size() == 64));
        check("rd_data", 32'(b.rd_data), q.size() > 0 ? 32'(q[0]) : 32'd0);
        check("pkt_address", 32'(b.pkt_address), 32'(ma));
    endtask

    task automatic scyc(input logic w, input logic [17:0] d, input logic r);
        logic wok, rok;
        s.wr_en = w; s.wr_data = d; s.rd_en = r;
        rok = r && sq.size() > 0;
        wok = w && (sq.size() < 5 || r);
        if (rok) check("s_rd_head", 32'(s.rd_data), 32'(sq.pop_front()));
        if (wok) sq.push_back(d);
        @(posedge clk); #1;
        s.wr_en = 0; s.rd_en = 0;
        check("s_count", 32'(s.count), 32'(sq.size()));
    endtask

    initial begin
        b.wr_en = 0; b.wr_data = 0; b.rd_en = 0;
        s.wr_en = 0; s.wr_data = 0; s.rd_en = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_empty", 32'(b.empty), 1);
        check("rst_count", 32'(b.count), 0);
        check("rst_rd_data", 32'(b.rd_data), 0);
        check("rst_pkt", 32'(b.pkt_address), 0);
        repeat (3) cyc(0, 0, 1);
        cyc(1, 18'h10005, 0);
        cyc(1, 18'h200AA, 0);
        cyc(1, 18'h300BB, 0);
        repeat (3) cyc(0, 0, 1);
        for (int i = 0; i < 64; i++) cyc(1, {2'b10, 16'(i * 7 + 3)}, 0);
        cyc(1, 18'h3DEAD, 0);
        cyc(1, 18'h2BEEF, 1);
        repeat (64) cyc(0, 0, 1);
        cyc(1, 18'h21234, 1);
        cyc(0, 0, 1);
        cyc(1, 18'h10005, 0);
        cyc(1, 18'h20011, 0);
        cyc(1, 18'h20022, 0);
        #3 rst = 1;
        #1;
        check("arst_empty", 32'(b.empty), 1);
        check("arst_count", 32'(b.count), 0);
        check("arst_pkt", 32'(b.pkt_address), 0);
        check("arst_rd_data", 32'(b.rd_data), 0);
        q.delete();
        ma = 0;
        @(posedge clk); #1 rst = 0;
        cyc(1, 18'h1000A, 0);
        cyc(1, 18'h30077, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        scyc(1, 18'h20100, 0);
        scyc(1, 18'h20101, 0);
        for (int i = 0; i < 12; i++) scyc(1, {2'b10, 16'(16'h0200 + i)}, 1);
        scyc(0, 0, 1);
        scyc(0, 0, 1);
        check("s_empty", 32'(s.empty), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
